// File: rtl/data_bank_write_ctrl.sv
// Write-port controller for the cache data banks: arbitrates line-atomic refills
// against single-word store hits and drives registered one-cycle bank write strobes.
module data_bank_write_ctrl #(
    parameter int unsigned NBANK  = 4,
    parameter int unsigned SET_W  = 6,
    parameter int unsigned WAYS   = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       refill_req_valid,
    output logic                       refill_req_ready,
    input  logic [SET_W-1:0]           refill_set,
    input  logic [WAYS-1:0]            refill_way,
    input  logic                       refill_beat_valid,
    output logic                       refill_beat_ready,
    input  logic [DATA_W-1:0]          refill_beat_data,
    output logic                       refill_done,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [SET_W-1:0]           st_set,
    input  logic [WAYS-1:0]            st_way,
    input  logic [$clog2(NBANK)-1:0]   st_bank,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [(DATA_W/8)-1:0]      st_mask,
    output logic [NBANK-1:0]           bank_w_en,
    output logic [SET_W-1:0]           bank_w_set,
    output logic [WAYS-1:0]            bank_w_way,
    output logic [DATA_W-1:0]          bank_w_data,
    output logic [(DATA_W/8)-1:0]      bank_w_mask,
    output logic                       busy
);

    localparam int unsigned BANK_W = $clog2(NBANK);
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [BANK_W-1:0]   beat_cnt;
    logic                st_prio;
    logic [SET_W-1:0]    fill_set;
    logic [WAYS-1:0]     fill_way;

    logic                refill_acc;
    logic                beat_acc;
    logic                st_acc;
    logic                wr_issue;
    logic [NBANK-1:0]    wr_en;
    logic [SET_W-1:0]    wr_set;
    logic [WAYS-1:0]     wr_way;
    logic [DATA_W-1:0]   wr_data;
    logic [MASK_W-1:0]   wr_mask;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (refill_acc) next_state = FILL;
            FILL:    if (beat_acc && (beat_cnt == BANK_W'(NBANK - 1))) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs; held low while reset is asserted
    always_comb begin
        refill_req_ready  = 1'b0;
        st_ready          = 1'b0;
        refill_beat_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    refill_req_ready = !st_prio || !st_valid;
                    st_ready         = !refill_req_valid || st_prio;
                end
                FILL:    refill_beat_ready = 1'b1;
                default: ;
            endcase
        end
    end

    assign refill_acc = refill_req_valid  && refill_req_ready;
    assign beat_acc   = refill_beat_valid && refill_beat_ready;
    assign st_acc     = st_valid          && st_ready;
    assign wr_issue   = st_acc || beat_acc;

    // Write payload for the next strobe cycle; stores and beats never coincide
    always_comb begin
        wr_en   = '0;
        wr_set  = fill_set;
        wr_way  = fill_way;
        wr_data = refill_beat_data;
        wr_mask = '1;
        if (st_acc) begin
            wr_en   = NBANK'(1) << st_bank;
            wr_set  = st_set;
            wr_way  = st_way;
            wr_data = st_data;
            wr_mask = st_mask;
        end else if (beat_acc) begin
            wr_en   = NBANK'(1) << beat_cnt;
        end
    end

    // Refill bookkeeping and store-priority flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
            st_prio  <= 1'b0;
            fill_set <= '0;
            fill_way <= '0;
        end else begin
            if (refill_acc) begin
                beat_cnt <= '0;
                fill_set <= refill_set;
                fill_way <= refill_way;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + BANK_W'(1);
            end
            if (refill_acc && st_valid) st_prio <= 1'b1;
            else if (st_acc)            st_prio <= 1'b0;
        end
    end

    // Registered bank write port and status
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bank_w_en   <= '0;
            bank_w_set  <= '0;
            bank_w_way  <= '0;
            bank_w_data <= '0;
            bank_w_mask <= '0;
            refill_done <= 1'b0;
            busy        <= 1'b0;
        end else begin
            bank_w_en   <= wr_en;
            if (wr_issue) begin
                bank_w_set  <= wr_set;
                bank_w_way  <= wr_way;
                bank_w_data <= wr_data;
                bank_w_mask <= wr_mask;
            end
            refill_done <= (next_state == DONE);
            busy        <= (next_state != IDLE);
        end
    end

endmodule
